// File: rtl/sample03_pkg.sv
// rtl/sample03_pkg.sv - shared defaults and state type for the response capture block
package sample03_pkg;

    localparam int          SIG_W_DEF     = 16;
    localparam int          CNT_W_DEF     = 8;
    localparam logic [15:0] MISR_POLY_DEF = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/misr16.sv
// rtl/misr16.sv - multiple-input signature register folding a 3-bit response per enabled cycle
module misr16
    import sample03_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ {{(SIG_W-3){1'b0}}, din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/sample03_capture.sv
// rtl/sample03_capture.sv - captures a window of r/s/t response vectors into a signature and ones-counts
module sample03_capture
    import sample03_pkg::*;
#(
    parameter int               SIG_W     = SIG_W_DEF,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(MISR_POLY_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic             r,
    input  logic             s,
    input  logic             t,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_s,
    output logic [CNT_W-1:0] cnt_t,
    output logic [CNT_W-1:0] vec_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
    logic [CNT_W-1:0] cnt_s_q, cnt_s_d;
    logic [CNT_W-1:0] cnt_t_q, cnt_t_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic             misr_clr;
    logic             misr_en;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_r_d  = cnt_r_q;
        cnt_s_d  = cnt_s_q;
        cnt_t_d  = cnt_t_q;
        vec_d    = vec_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = len;
                    cnt_r_d  = '0;
                    cnt_s_d  = '0;
                    cnt_t_d  = '0;
                    vec_d    = '0;
                    misr_clr = 1'b1;
                    state_d  = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    misr_en = 1'b1;
                    // ones-counters saturate rather than wrap
                    if (r && (cnt_r_q != '1)) cnt_r_d = cnt_r_q + 1'b1;
                    if (s && (cnt_s_q != '1)) cnt_s_d = cnt_s_q + 1'b1;
                    if (t && (cnt_t_q != '1)) cnt_t_d = cnt_t_q + 1'b1;
                    vec_d = vec_q + 1'b1;
                    if (vec_d == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_r_q <= '0;
            cnt_s_q <= '0;
            cnt_t_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_r_q <= cnt_r_d;
            cnt_s_q <= cnt_s_d;
            cnt_t_q <= cnt_t_d;
            vec_q   <= vec_d;
        end
    end

    misr16 #(
        .SIG_W (SIG_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din ({r, s, t}),
        .sig (sig)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done_valid = (state_q == ST_DONE);
    assign cnt_r      = cnt_r_q;
    assign cnt_s      = cnt_s_q;
    assign cnt_t      = cnt_t_q;
    assign vec_cnt    = vec_q;

endmodule

// File: tb/tb_sample03_capture.sv
// tb/tb_sample03_capture.sv - directed self-checking bench for sample03_capture
module tb_sample03_capture;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        r, s, t;
    logic        busy;
    logic        done_valid;
    logic        done_ready;
    logic [15:0] sig;
    logic [7:0]  cnt_r, cnt_s, cnt_t, vec_cnt;

    int checks = 0;
    int errors = 0;

    sample03_capture dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .r          (r),
        .s          (s),
        .t          (t),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .sig        (sig),
        .cnt_r      (cnt_r),
        .cnt_s      (cnt_s),
        .cnt_t      (cnt_t),
        .vec_cnt    (vec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int misr_next(input int sg, input int v);
        int n;
        n = (sg << 1) & 32'hFFFF;
        if ((sg & 32'h8000) != 0) n = n ^ 32'h1021;
        return n ^ v;
    endfunction

    // Reference: mode 0 = idle, 1 = collecting, 2 = results offered
    int m_mode = 0;
    int m_len  = 0;
    int m_sig  = 0;
    int m_cr   = 0;
    int m_cs   = 0;
    int m_ct   = 0;
    int m_vc   = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_sig = 0; m_cr = 0; m_cs = 0; m_ct = 0; m_vc = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_len = int'(len);
                m_sig = 0; m_cr = 0; m_cs = 0; m_ct = 0; m_vc = 0;
                m_mode = (m_len == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_sig = misr_next(m_sig, int'({r, s, t}));
                if (r) m_cr = (m_cr + 1 > 255) ? 255 : m_cr + 1;
                if (s) m_cs = (m_cs + 1 > 255) ? 255 : m_cs + 1;
                if (t) m_ct = (m_ct + 1 > 255) ? 255 : m_ct + 1;
                m_vc = m_vc + 1;
                if (m_vc == m_len) m_mode = 2;
            end
        end else begin
            if (done_ready) m_mode = 0;
        end
    end

    always @(negedge clk) begin
        check("cmp_sig",        32'(sig),        32'(m_sig));
        check("cmp_cnt_r",      32'(cnt_r),      32'(m_cr));
        check("cmp_cnt_s",      32'(cnt_s),      32'(m_cs));
        check("cmp_cnt_t",      32'(cnt_t),      32'(m_ct));
        check("cmp_vec_cnt",    32'(vec_cnt),    32'(m_vc));
        check("cmp_busy",       32'(busy),       32'(m_mode != 0));
        check("cmp_done_valid", 32'(done_valid), 32'(m_mode == 2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic vec(input logic [2:0] v);
        in_valid  = 1'b1;
        {r, s, t} = v;
        step();
        in_valid  = 1'b0;
        {r, s, t} = 3'b000;
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check("hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int e;
        rst = 1'b0;
        start = 1'b0; len = 8'd0; in_valid = 1'b0; done_ready = 1'b0;
        {r, s, t} = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sig",  32'(sig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dv",   32'(done_valid), 32'd0);
        check("rst_vec",  32'(vec_cnt), 32'd0);
        rst = 1'b1;
        step();

        // single vector window
        do_start(8'd1);
        vec(3'b101);
        check("t1_sig", 32'(sig), 32'h0005);
        check("t1_cr",  32'(cnt_r), 32'd1);
        check("t1_cs",  32'(cnt_s), 32'd0);
        check("t1_ct",  32'(cnt_t), 32'd1);
        check("t1_vec", 32'(vec_cnt), 32'd1);
        check("t1_dv",  32'(done_valid), 32'd1);
        handshake();

        // two vectors with a gap of three idle cycles
        do_start(8'd2);
        vec(3'b101);
        repeat (3) begin
            check("t2_gap_busy", 32'(busy), 32'd1);
            check("t2_gap_dv",   32'(done_valid), 32'd0);
            step();
        end
        vec(3'b010);
        check("t2_sig", 32'(sig), 32'h0008);
        check("t2_vec", 32'(vec_cnt), 32'd2);
        check("t2_dv",  32'(done_valid), 32'd1);
        handshake();

        // in_valid while idle changes nothing
        in_valid = 1'b1; {r, s, t} = 3'b111;
        repeat (2) step();
        in_valid = 1'b0; {r, s, t} = 3'b000;
        check("idle_vec", 32'(vec_cnt), 32'd2);
        check("idle_sig", 32'(sig), 32'h0008);

        // zero-length window, consumer stalls
        do_start(8'd0);
        check("t3_dv",  32'(done_valid), 32'd1);
        check("t3_sig", 32'(sig), 32'd0);
        check("t3_vec", 32'(vec_cnt), 32'd0);
        repeat (5) step();
        check("t3_hold_dv",  32'(done_valid), 32'd1);
        check("t3_hold_sig", 32'(sig), 32'd0);
        handshake();

        // long window with excess vectors after completion
        do_start(8'd255);
        in_valid = 1'b1; {r, s, t} = 3'b111;
        repeat (300) step();
        in_valid = 1'b0; {r, s, t} = 3'b000;
        e = 0;
        repeat (255) e = misr_next(e, 7);
        check("t4_sig", 32'(sig), 32'(e));
        check("t4_vec", 32'(vec_cnt), 32'd255);
        check("t4_cr",  32'(cnt_r), 32'd255);
        check("t4_cs",  32'(cnt_s), 32'd255);
        check("t4_ct",  32'(cnt_t), 32'd255);
        check("t4_dv",  32'(done_valid), 32'd1);
        handshake();

        // reset mid-window, then a clean restart
        do_start(8'd20);
        repeat (10) vec(3'b110);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_sig",  32'(sig), 32'd0);
        check("t5_rst_vec",  32'(vec_cnt), 32'd0);
        check("t5_rst_cr",   32'(cnt_r), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_dv",   32'(done_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        do_start(8'd3);
        vec(3'b100);
        vec(3'b011);
        vec(3'b111);
        check("t5_sig", 32'(sig), 32'h0011);
        check("t5_cr",  32'(cnt_r), 32'd2);
        check("t5_cs",  32'(cnt_s), 32'd2);
        check("t5_ct",  32'(cnt_t), 32'd2);
        check("t5_vec", 32'(vec_cnt), 32'd3);
        check("t5_dv",  32'(done_valid), 32'd1);
        handshake();

        // start coincident with the done handshake is dropped
        do_start(8'd1);
        vec(3'b001);
        check("t6_dv", 32'(done_valid), 32'd1);
        start = 1'b1; len = 8'd5; done_ready = 1'b1;
        step();
        start = 1'b0; len = 8'd0; done_ready = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_dv0",  32'(done_valid), 32'd0);
        step();
        check("t6_busy2", 32'(busy), 32'd0);
        check("t6_vec",   32'(vec_cnt), 32'd1);
        check("t6_sig",   32'(sig), 32'h0001);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample03_capture.md
SAMPLE03_CAPTURE -- requirements
Module: sample03_capture

Interface
REQ-001 Parameter SIG_W, default 16: width of the MISR signature register.
REQ-002 Parameter CNT_W, default 8: width of the vector counter and of each per-output ones-counter.
REQ-003 Parameter MISR_POLY, default 16'h1021: MISR feedback polynomial.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that opens a capture window; honoured in IDLE only.
REQ-008 len  input  CNT_W  number of vectors in the window; sampled on an accepted start.
REQ-009 in_valid  input  1  r/s/t carry a valid response vector this cycle.
REQ-010 r, s, t  input  1 each  response bits from the upstream combinational stage.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done_valid  output  1  high in DONE; results are stable while it is high.
REQ-013 done_ready  input  1  consumer accepts the results.
REQ-014 sig  output  SIG_W  MISR signature.
REQ-015 cnt_r, cnt_s, cnt_t  output  CNT_W each  ones-count of each response bit.
REQ-016 vec_cnt  output  CNT_W  number of vectors captured in the current or last window.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: start=1 with len!=0 -> RUN; latch len; clear sig, counters and vec_cnt to 0.
REQ-019 IDLE: start=1 with len==0 -> DONE next cycle; clear all results to 0.
REQ-020 RUN: each cycle with in_valid=1 captures one vector and increments vec_cnt by 1.
REQ-021 Capture: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ {0…,r,s,t}, with r at bit 2 and t at bit 0.
REQ-022 Capture: cnt_x increments when x=1 and saturates at 2^CNT_W-1, for x in {r,s,t}.
REQ-023 RUN -> DONE on the edge that captures vector number len; the outputs reflect the final vector in the first DONE cycle.
REQ-024 RUN with in_valid=0: no state change and no timeout.
REQ-025 DONE: done_valid=1; done_valid && done_ready -> IDLE next cycle; results hold their values until the next accepted start.
REQ-026 A start pulse in RUN or DONE is ignored, including a start coincident with the done handshake.
REQ-027 in_valid in IDLE or DONE is ignored; no result changes.
REQ-028 In IDLE, busy=0 and done_valid=0; results keep the values of the last window.
REQ-029 There is no combinational path from any input to any output; all outputs are registered.

Reset
REQ-030 While rst=0, the FSM is forced to IDLE and sig, cnt_r, cnt_s, cnt_t, vec_cnt, busy and done_valid are forced to 0, independent of clk.
REQ-031 A reset asserted mid-window discards the partial window; no done_valid is produced for it.
REQ-032 After rst deasserts, the first accepted start occurs no earlier than the first rising clk edge.

Structure
REQ-033 Package sample03_pkg shall hold SIG_W, CNT_W, MISR_POLY defaults and the state enum type.
REQ-034 The MISR register and next-state logic shall be sub-module misr16 (ports: clk, rst, clr, en, din[2:0], sig); the FSM and counters reside in sample03_capture.

Verification
REQ-035 Reset, then start with len=1 and one vector rst=101 -> sig=0x0005, cnt_r=1, cnt_s=0, cnt_t=1, vec_cnt=1, done_valid=1 in the next cycle.
REQ-036 len=2, vectors 101 then 010, with in_valid gapped by 3 idle cycles -> sig=0x0008, vec_cnt=2, DONE is entered only after the second vector.
REQ-037 len=0 start -> DONE after 1 cycle, with all results 0; done_ready held 0 for 5 cycles -> done_valid stays 1 and the results stay stable.
REQ-038 len=255 window with 300 valid vectors of 111 (the 45 excess vectors arrive after DONE) -> vec_cnt=255, cnt_r=cnt_s=cnt_t=255, the excess is ignored, and sig matches the model value.
REQ-039 rst pulled low at vector 10 of len=20 -> all outputs 0 immediately; a restart with len=3 produces correct results.
REQ-040 start coincident with done_ready in DONE -> return to IDLE, start ignored, busy=0 in the next cycle.
